// File: rtl/sha256_msg_sched_if.sv
// sha256_msg_sched_if: block-input and schedule-word-output bundle for the SHA-256 message scheduler
interface sha256_msg_sched_if;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         abort;
  logic         w_valid;
  logic         w_ready;
  logic [31:0]  w_data;
  logic [5:0]   w_round;
  logic         w_last;
  logic [31:0]  wk_data;
  logic         busy;
  modport slave (
    input  blk_valid, blk_data, abort, w_ready,
    output blk_ready, w_valid, w_data, w_round, w_last, wk_data, busy
  );
  modport master (
    output blk_valid, blk_data, abort, w_ready,
    input  blk_ready, w_valid, w_data, w_round, w_last, wk_data, busy
  );
endinterface

// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched: streams W[0..63] from a 16-word sliding window; define SHA256_SCHED_KROM_EN
// to add the K[t] ROM so wk_data carries W[t] + K[t] instead of W[t].
module sha256_msg_sched (
  input logic clk,
  input logic rst,
  sha256_msg_sched_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t      r_state, w_next;
  logic [31:0] r_win [16];
  logic [5:0]  r_round;
  logic        w_load, w_adv;
  logic [31:0] w_new;
`ifdef SHA256_SCHED_KROM_EN
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
`endif
  function automatic logic [31:0] sigma_shift_0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction
  function automatic logic [31:0] sigma_shift_1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction
  assign w_new = sigma_shift_1(r_win[14]) + r_win[9] + sigma_shift_0(r_win[1]) + r_win[0];
  // abort wins over w_ready so an aborted cycle never counts as a handshake
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_adv  = 1'b0;
    if (r_state == IDLE) begin
      w_load = bus.blk_valid;
      w_next = bus.blk_valid ? RUN : IDLE;
    end else if (bus.abort) begin
      w_next = IDLE;
    end else if (bus.w_ready) begin
      w_adv  = 1'b1;
      w_next = (r_round == 6'd63) ? IDLE : RUN;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_round <= '0;
      for (int i = 0; i < 16; i++) r_win[i] <= '0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        for (int i = 0; i < 16; i++) r_win[i] <= bus.blk_data[511-32*i -: 32];
        r_round <= '0;
      end else if (w_adv) begin
        for (int i = 0; i < 15; i++) r_win[i] <= r_win[i+1];
        r_win[15] <= w_new;
        r_round   <= r_round + 6'd1;
      end else if (r_state == RUN && bus.abort) begin
        r_round <= '0;
      end
    end
  end
  assign bus.blk_ready = (r_state == IDLE);
  assign bus.w_valid   = (r_state == RUN);
  assign bus.busy      = (r_state == RUN);
  assign bus.w_data    = r_win[0];
  assign bus.w_round   = r_round;
  assign bus.w_last    = (r_state == RUN) && (r_round == 6'd63);
`ifdef SHA256_SCHED_KROM_EN
  assign bus.wk_data   = r_win[0] + K[r_round];
`else
  assign bus.wk_data   = r_win[0];
`endif
endmodule

// File: tb/tb_sha256_msg_sched.sv
// tb_sha256_msg_sched: directed vectors plus stall, back-to-back, abort and async-reset sequences
module tb_sha256_msg_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  sha256_msg_sched_if bus();
  sha256_msg_sched dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
  logic [31:0] g [64];
  logic [31:0] obs [64];
  logic [31:0] obs_wk0;
  typedef struct {int t; logic [31:0] w;} vec_t;
  vec_t tbl [6];
`ifdef SHA256_SCHED_KROM_EN
  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [31:0] WK0_ABC = 32'hA3EC9318;
`else
  localparam logic [31:0] WK0_ABC = 32'h61626380;
`endif
  function automatic logic [31:0] kk(input int t);
`ifdef SHA256_SCHED_KROM_EN
    return KT[t];
`else
    return (t < 0) ? 32'h1 : 32'h0;
`endif
  endfunction
  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask
  task automatic calc_gold(input logic [511:0] b);
    for (int t = 0; t < 16; t++) g[t] = b[511-32*t -: 32];
    for (int t = 16; t < 64; t++)
      g[t] = (ror(g[t-2], 17) ^ ror(g[t-2], 19) ^ (g[t-2] >> 10)) + g[t-7]
           + (ror(g[t-15], 7) ^ ror(g[t-15], 18) ^ (g[t-15] >> 3)) + g[t-16];
  endtask
  task automatic check_reset(input string tag);
    chk({tag, "_blk_ready"}, bus.blk_ready, 1);
    chk({tag, "_w_valid"}, bus.w_valid, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_w_round"}, bus.w_round, 0);
    chk({tag, "_w_last"}, bus.w_last, 0);
    chk({tag, "_w_data"}, bus.w_data, 0);
    chk({tag, "_wk_data"}, bus.wk_data, kk(0));
  endtask
  task automatic follow(input bit stall);
    int t = 0;
    int cyc = 0;
    bit held = 0;
    logic [31:0] pd, pw;
    logic [5:0] pr;
    while (t < 64 && cyc < 1000) begin
      chk("w_valid", bus.w_valid, 1);
      chk("w_round", bus.w_round, t[5:0]);
      chk("w_data", bus.w_data, g[t]);
      chk("w_last", bus.w_last, t == 63);
      chk("wk_data", bus.wk_data, g[t] + kk(t));
      chk("blk_ready_run", bus.blk_ready, 0);
      if (held) begin
        chk("stall_data", bus.w_data, pd);
        chk("stall_wk", bus.wk_data, pw);
        chk("stall_round", bus.w_round, pr);
      end
      obs[t] = bus.w_data;
      if (t == 0) obs_wk0 = bus.wk_data;
      bus.w_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      held = !bus.w_ready;
      pd = bus.w_data;
      pw = bus.wk_data;
      pr = bus.w_round;
      if (bus.w_ready) t++;
      @(negedge clk);
      cyc++;
    end
    chk("stream_done", t, 64);
    chk("ready_after_last", bus.blk_ready, 1);
    chk("valid_after_last", bus.w_valid, 0);
  endtask
  task automatic accept(input logic [511:0] b);
    calc_gold(b);
    bus.blk_data = b;
    bus.blk_valid = 1'b1;
    chk("blk_ready_idle", bus.blk_ready, 1);
    @(negedge clk);
    bus.blk_valid = 1'b0;
  endtask
  task automatic stream(input logic [511:0] b, input bit stall);
    accept(b);
    follow(stall);
  endtask
  function automatic logic [511:0] rand_blk();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[511-32*i -: 32] = $urandom();
    return b;
  endfunction
  initial begin
    #500_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [511:0] abc, rb, a, b;
    int acc [$];
    bus.blk_valid = 1'b0;
    bus.blk_data = '0;
    bus.abort = 1'b0;
    bus.w_ready = 1'b0;
    tbl = '{'{0, 32'h61626380}, '{1, 32'h0}, '{15, 32'h18},
            '{16, 32'h61626380}, '{17, 32'h000F0000}, '{18, 32'h7DA86405}};
    #12;
    check_reset("rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset("idle");
    abc = {32'h61626380, 448'h0, 32'h00000018};
    bus.w_ready = 1'b1;
    stream(abc, 1'b0);
    for (int i = 0; i < 6; i++)
      chk($sformatf("abc_W%0d", tbl[i].t), obs[tbl[i].t], tbl[i].w);
    chk("abc_wk0", obs_wk0, WK0_ABC);
    rb = rand_blk();
    stream(rb, 1'b0);
    stream(rb, 1'b1);
    a = rand_blk();
    b = rand_blk();
    calc_gold(b);
    bus.blk_data = a;
    bus.blk_valid = 1'b1;
    bus.w_ready = 1'b1;
    for (int c = 0; c < 200 && acc.size() < 2; c++) begin
      if (bus.blk_ready) acc.push_back(c);
      if (bus.w_valid && bus.w_round == 6'd63) chk("ready_low_r63", bus.blk_ready, 0);
      @(negedge clk);
      if (acc.size() >= 1) bus.blk_data = b;
    end
    bus.blk_valid = 1'b0;
    chk("b2b_accepts", acc.size(), 2);
    if (acc.size() == 2) chk("b2b_period", acc[1] - acc[0], 65);
    follow(1'b0);
    bus.w_ready = 1'b1;
    accept(rand_blk());
    for (int c = 0; c < 30 && bus.w_round != 6'd20; c++) @(negedge clk);
    chk("abort_reach", bus.w_round, 20);
    chk("abort_w20", bus.w_data, g[20]);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_w_valid", bus.w_valid, 0);
    chk("abort_blk_ready", bus.blk_ready, 1);
    chk("abort_w_round", bus.w_round, 0);
    chk("abort_busy", bus.busy, 0);
    @(negedge clk);
    chk("abort_no_w21", bus.w_valid, 0);
    a = rand_blk();
    calc_gold(a);
    bus.blk_data = a;
    bus.blk_valid = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.blk_valid = 1'b0;
    bus.abort = 1'b0;
    follow(1'b0);
    accept(rand_blk());
    for (int c = 0; c < 50 && bus.w_round != 6'd37; c++) @(negedge clk);
    chk("rst_reach", bus.w_round, 37);
    #2 rst = 1'b1;
    #1 check_reset("async");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    stream(rand_blk(), 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sha256_msg_sched.md
# sha256_msg_sched

Message-schedule sequencer for the SHA-256 compression core. It accepts one 512-bit padded block over a valid/ready handshake. It then streams the 64 schedule words W[0..63], one per accepted handshake, to the round datapath. Words 16–63 are generated in place from a 16-word sliding window using the σ0/σ1 small-sigma functions (sigma_shift_0, sigma_shift_1). It sits between the block padder/loader and the compression round engine, and is the only block that sequences round numbering.

## Interface
Parameters: none.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- blk_valid  in  1  padded block available
- blk_ready  out  1  block can be accepted
- blk_data  in  512  block; W[0] = [511:480], W[15] = [31:0] (big-endian word order)
- abort  in  1  synchronous cancel of block in progress
- w_valid  out  1  schedule word valid
- w_ready  in  1  round engine consumes word
- w_data  out  32  W[t]
- w_round  out  6  t, 0..63
- w_last  out  1  high with t = 63
- wk_data  out  32  (W[t] + K[t]) mod 2^32; see Configuration
- busy  out  1  state != IDLE

## Operation
- States: IDLE, RUN.
- IDLE:
  - blk_ready = 1, w_valid = 0.
  - On blk_valid & blk_ready: load window win[0..15] with W[0..15], round = 0, go to RUN.
- RUN:
  - blk_ready = 0, w_valid = 1.
  - w_data = win[0], w_round = round.
  - On w_valid & w_ready:
    - shift window down one word (win[i] ← win[i+1]);
    - win[15] ← σ1(win[14]) + win[9] + σ0(win[1]) + win[0], mod 2^32;
    - round += 1.
  - Handshake with round = 63 returns to IDLE; round wraps to 0. The generated word is discarded.
- Generation for t ≥ 16 always uses this recurrence. Words 0..15 come straight from blk_data.
- Stall: while w_ready = 0, w_data, w_round, w_last and wk_data hold stable and no state changes.
- Abort:
  - In RUN, abort = 1 forces IDLE on the next edge. The window is left stale, round clears to 0, and no handshake counts that cycle even if w_ready = 1.
  - In IDLE, abort is ignored; a simultaneous blk_valid is still accepted.
- Arithmetic: all additions are 32-bit modulo. Carries are dropped.

## Timing
- Reset values:
  - blk_ready = 1 (IDLE), w_valid = 0, busy = 0.
  - w_round = 0, w_last = 0.
  - w_data = 0 and win = all-zero; wk_data = 0x428A2F98 with KROM enabled, 0 without.
- Latency: block accepted at edge N gives w_valid = 1 with W[0] after edge N.
- Throughput: 64 handshakes plus 1 IDLE accept cycle, so a minimum of 65 cycles per block with w_ready held high.
- blk_ready is 0 during the cycle of the round-63 handshake. The earliest next acceptance is the following cycle.
- All outputs are registered or decoded from registers only; there is no combinational path from w_ready or blk_valid to any output.
- Asynchronous rst mid-RUN goes to IDLE immediately with the reset values above. Any partial block is lost.

## Configuration
- Macro: SHA256_SCHED_KROM_EN.
- Defined:
  - Internal 64×32 round-constant ROM (FIPS 180-4 K[0..63]), indexed by round.
  - wk_data = w_data + K[round].
  - The round engine needs a single adder for the W+K term.
- Undefined:
  - No ROM.
  - wk_data = w_data; the round engine supplies K itself.
- Handshake, latency and all other behaviour are identical in both builds.

## Test plan
- "abc" block (W0 = 0x61626380, W1–W14 = 0, W15 = 0x00000018), w_ready held 1:
  - w_round 0..63 on consecutive cycles;
  - W16 = 0x61626380, W17 = 0x000F0000;
  - W[0..63] match the software golden model;
  - w_last only at round 63;
  - blk_ready returns 1 exactly 1 cycle after the round-63 handshake.
- KROM enabled, same block: wk_data at round 0 = 0xA3EC9318. KROM disabled: wk_data = 0x61626380.
- Random w_ready stalls (≈50%) on a random block:
  - output stream identical to the no-stall run;
  - w_data, w_round and wk_data stable across every stalled cycle.
- Back-to-back blocks, blk_valid held high:
  - second block accepted on the first IDLE cycle;
  - 65-cycle period;
  - second stream starts at round 0 with the second block's W0.
- abort at round 20 with w_ready = 1:
  - next cycle w_valid = 0, blk_ready = 1, w_round = 0;
  - no word 21 emitted;
  - a following block streams correctly from W0.
- rst asserted asynchronously mid-RUN (round 37) between clock edges:
  - outputs take reset values without waiting for a clock edge;
  - after release, a new block is accepted and streams correctly.
